// File: rtl/spi_mem_writer_if.sv
// Bus between an SPI bit-event source and the spi_mem_writer memory write port.
interface spi_mem_writer_if #(
  parameter int unsigned AW = 12
);
  logic          sel;
  logic          rising;
  logic          falling;
  logic          si;
  logic          reset_flag;
  logic          we;
  logic [15:0]   wdata;
  logic [AW-1:0] addr;
  logic          overflow;

  modport master (
    output sel, rising, falling, si, reset_flag,
    input  we, wdata, addr, overflow
  );

  modport slave (
    input  sel, rising, falling, si, reset_flag,
    output we, wdata, addr, overflow
  );
endinterface

// File: rtl/spi_mem_writer.sv
// Assembles MSB-first SPI bits into 16-bit words and writes them to sequential addresses.
// SPI_MEM_WRITER_WRAP_EN: wrap the address at the top instead of saturating and dropping words.
module spi_mem_writer #(
  parameter int unsigned AW = 12
) (
  input  logic             clk,
  input  logic             rst,
  spi_mem_writer_if.slave  bus
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam logic [AW-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [DW-1:0]  shreg_q;
  logic [CW-1:0]  cnt_q;
  logic           full_q;
  logic           we_q;
  logic [DW-1:0]  wdata_q;
  logic [AW-1:0]  addr_q;
  logic           ovf_q;

  logic           accept_c;
  logic           word_done_c;
  logic           write_ok_c;
  logic           load_c;
  logic [DW-1:0]  shreg_next_c;
  logic [AW-1:0]  addr_next_c;

  // SCK falling edges carry no data for this mode
  logic unused_falling;
  assign unused_falling = bus.falling;

  assign accept_c     = bus.sel & bus.rising;
  assign word_done_c  = accept_c & (cnt_q == CW'(DW - 1));
  assign shreg_next_c = {shreg_q[DW-2:0], bus.si};

`ifdef SPI_MEM_WRITER_WRAP_EN
  assign write_ok_c  = 1'b1;
  assign addr_next_c = addr_q + AW'(1);
`else
  // Once the top address has been written, later words are dropped
  assign write_ok_c  = ~full_q;
  assign addr_next_c = (addr_q == ADDR_MAX) ? addr_q : addr_q + AW'(1);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; reset_flag overrides everything
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) state_d = SHIFT;
      end
      SHIFT: begin
        if (word_done_c && write_ok_c) begin
          state_d = WRITE;
          load_c  = 1'b1;
        end
      end
      WRITE: begin
        state_d = SHIFT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (bus.reset_flag) begin
      state_d = IDLE;
      load_c  = 1'b0;
    end
  end

  // Datapath: shift register, bit counter, write holding register, address and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      we_q <= (state_d == WRITE);
      if (load_c) wdata_q <= shreg_next_c;
      if (bus.reset_flag) begin
        shreg_q <= '0;
        cnt_q   <= '0;
        full_q  <= 1'b0;
        addr_q  <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (accept_c) begin
          shreg_q <= shreg_next_c;
          cnt_q   <= cnt_q + CW'(1);
        end
        if (word_done_c && full_q) ovf_q <= 1'b1;
        // Address advances at the end of the write pulse cycle
        if (state_q == WRITE) begin
          if (addr_q == ADDR_MAX) full_q <= 1'b1;
          addr_q <= addr_next_c;
        end
      end
    end
  end

  assign bus.we       = we_q;
  assign bus.wdata    = wdata_q;
  assign bus.addr     = addr_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_spi_mem_writer.sv
// Scoreboard bench for spi_mem_writer: two instances (AW=12 and AW=2) share one stimulus stream.
module tb_spi_mem_writer;

  localparam int unsigned AW_A = 12;
  localparam int unsigned AW_B = 2;
`ifdef SPI_MEM_WRITER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;
    int          addr;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t qa[$];
  exp_t qb[$];
  int          m_cnt[2];
  int          m_addr[2];
  logic [15:0] m_sh[2];
  bit          m_full[2];
  bit          m_ovf[2];
  int          m_push[2];
  int          n_wr[2];
  int          amax[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_mem_writer_if #(.AW(AW_A)) bus_a();
  spi_mem_writer_if #(.AW(AW_B)) bus_b();

  spi_mem_writer #(.AW(AW_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  spi_mem_writer #(.AW(AW_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input int i);
    m_cnt[i]  = 0;
    m_sh[i]   = '0;
    m_addr[i] = 0;
    m_full[i] = 0;
    m_ovf[i]  = 0;
  endtask

  // Word-level reference: every 16 accepted bits form one word written to the next free address
  task automatic model_step(input int i, input bit acc, input bit d, input bit rf);
    exp_t e;
    if (rf) begin
      model_clear(i);
    end else if (acc) begin
      m_sh[i] = {m_sh[i][14:0], d};
      m_cnt[i]++;
      if (m_cnt[i] == 16) begin
        m_cnt[i] = 0;
        if (m_full[i]) m_ovf[i] = 1;
        if (!m_full[i] || WRAP) begin
          e.data = m_sh[i];
          e.addr = m_addr[i];
          e.cyc  = cyc + 1;
          if (i == 0) qa.push_back(e); else qb.push_back(e);
          m_push[i]++;
          if (m_addr[i] == amax[i]) begin
            m_full[i] = 1;
            m_addr[i] = WRAP ? 0 : amax[i];
          end else begin
            m_addr[i]++;
          end
        end
      end
    end
  endtask

  task automatic mon(input int i, input logic [15:0] d, input int a);
    exp_t e;
    n_wr[i]++;
    if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
      chk($sformatf("we_unexpected_%0d", i), 32'd1, 32'd0);
    end else begin
      e = (i == 0) ? qa.pop_front() : qb.pop_front();
      chk($sformatf("wdata_%0d", i), 32'(d), 32'(e.data));
      chk($sformatf("addr_%0d", i), 32'(a), 32'(e.addr));
      chk($sformatf("we_cycle_%0d", i), 32'(cyc), 32'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.we) mon(0, bus_a.wdata, int'(bus_a.addr));
      if (bus_b.we) mon(1, bus_b.wdata, int'(bus_b.addr));
    end
  end

  // One clock cycle of stimulus, applied at a falling edge
  task automatic drive(input bit s, input bit r, input bit d, input bit rf);
    bus_a.sel = s; bus_a.rising = r; bus_a.falling = s & ~r; bus_a.si = d; bus_a.reset_flag = rf;
    bus_b.sel = s; bus_b.rising = r; bus_b.falling = s & ~r; bus_b.si = d; bus_b.reset_flag = rf;
    model_step(0, s & r, d, rf);
    model_step(1, s & r, d, rf);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [15:0] w, input int hi, input int lo, input int gap);
    for (int b = hi; b >= lo; b--) begin
      drive(1'b1, 1'b1, w[b], 1'b0);
      repeat (gap - 1) drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_model(input string name);
    chk({name, "_addr_a"}, 32'(bus_a.addr), 32'(m_addr[0]));
    chk({name, "_ovf_a"}, 32'(bus_a.overflow), 32'(m_ovf[0]));
    chk({name, "_addr_b"}, 32'(bus_b.addr), 32'(m_addr[1]));
    chk({name, "_ovf_b"}, 32'(bus_b.overflow), 32'(m_ovf[1]));
    chk({name, "_writes_a"}, 32'(n_wr[0]), 32'(m_push[0]));
    chk({name, "_writes_b"}, 32'(n_wr[1]), 32'(m_push[1]));
  endtask

  task automatic check_zero(input string name);
    chk({name, "_we"}, 32'(bus_a.we), 32'd0);
    chk({name, "_wdata"}, 32'(bus_a.wdata), 32'd0);
    chk({name, "_addr"}, 32'(bus_a.addr), 32'd0);
    chk({name, "_ovf"}, 32'(bus_a.overflow), 32'd0);
    chk({name, "_b_wdata"}, 32'(bus_b.wdata), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    amax[0] = (1 << AW_A) - 1;
    amax[1] = (1 << AW_B) - 1;
    for (int i = 0; i < 2; i++) begin
      model_clear(i);
      m_push[i] = 0;
      n_wr[i]   = 0;
    end
    rst = 1'b1;
    bus_a.sel = 0; bus_a.rising = 0; bus_a.falling = 0; bus_a.si = 0; bus_a.reset_flag = 0;
    bus_b.sel = 0; bus_b.rising = 0; bus_b.falling = 0; bus_b.si = 0; bus_b.reset_flag = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Single word, one bit per clock
    send_bits(16'hA5C3, 15, 0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("first_addr_after", 32'(bus_a.addr), 32'd1);
    idle(2);
    check_model("single");

    // Back-to-back words, rising every two clocks
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(16'h0001, 15, 0, 2);
    send_bits(16'hFFFF, 15, 0, 2);
    send_bits(16'h8000, 15, 0, 2);
    idle(2);
    chk("b2b_addr", 32'(bus_a.addr), 32'd3);
    check_model("b2b");

    // Back-to-back words with a bit accepted in the write-pulse cycle
    send_bits(16'h1357, 15, 0, 1);
    send_bits(16'h9BDF, 15, 0, 1);
    idle(2);
    check_model("b2b_fast");

    // Partial word held across sel low (rising strobes ignored meanwhile)
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(16'h1234, 15, 9, 1);
    repeat (20) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    send_bits(16'h1234, 8, 0, 1);
    idle(2);
    chk("sel_hold_addr", 32'(bus_a.addr), 32'd1);
    check_model("sel_hold");

    // reset_flag discards a partial word
    send_bits(16'hFFFF, 15, 6, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(16'hBEEF, 15, 0, 1);
    idle(2);
    chk("rf_partial_addr", 32'(bus_a.addr), 32'd1);
    check_model("rf_partial");

    // reset_flag on the 16th bit suppresses the write
    send_bits(16'hCAFE, 15, 1, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);
    chk("rf_16th_addr", 32'(bus_a.addr), 32'd0);
    check_model("rf_16th");

    // reset_flag during the write pulse: write completes, address returns to 0
    send_bits(16'h5A5A, 15, 0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("rf_we_addr", 32'(bus_a.addr), 32'd0);
    check_model("rf_we");

    // Address exhaustion on the AW=2 instance
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      w = 16'($urandom);
      send_bits(w, 15, 0, 1 + (k % 2));
    end
    idle(2);
    chk("exhaust_ovf_b", 32'(bus_b.overflow), 32'd1);
    chk("exhaust_addr_b", 32'(bus_b.addr), WRAP ? 32'd1 : 32'd3);
    chk("exhaust_ovf_a", 32'(bus_a.overflow), 32'd0);
    check_model("exhaust");

    // Randomized traffic with occasional restarts
    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 79) == 0));
    end
    idle(2);
    check_model("random");

    // Asynchronous reset in the middle of a word
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(16'h7E81, 15, 0, 1);
    send_bits(16'hFFFF, 15, 11, 1);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    for (int i = 0; i < 2; i++) model_clear(i);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst = 1'b0;
    send_bits(16'h0F0F, 15, 0, 1);
    idle(2);
    chk("post_rst_wdata", 32'(bus_a.wdata), 32'h0F0F);
    chk("post_rst_addr", 32'(bus_a.addr), 32'd1);

    chk("queue_a_empty", 32'(qa.size()), 32'd0);
    chk("queue_b_empty", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
